// File: rtl/seq_encoder_pkg.sv
// -----------------------------------------------------------------------------
// seq_encoder_pkg
// Shared definitions for the sequential priority encoder slice.
//   - DEFAULT_N : default index width (vector width is 2**DEFAULT_N)
//   - VEC_MAX_W : widest request vector the helper function handles
//   - state_e   : drain FSM state encoding
//   - pop_is_one: true when exactly one bit of a vector is set
// -----------------------------------------------------------------------------
package seq_encoder_pkg;

  localparam int DEFAULT_N = 3;
  localparam int VEC_MAX_W = 256;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } state_e;

  // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero.
  function automatic logic pop_is_one(input logic [VEC_MAX_W-1:0] v);
    logic [VEC_MAX_W-1:0] rest_s;
    rest_s = v & (v - {{(VEC_MAX_W-1){1'b0}}, 1'b1});
    return (v != {VEC_MAX_W{1'b0}}) && (rest_s == {VEC_MAX_W{1'b0}});
  endfunction

endpackage

// File: rtl/seq_encoder_if.sv
// -----------------------------------------------------------------------------
// seq_encoder_if
// Request-vector input handshake and index output handshake of seq_encoder.
//   in_valid/in_ready/in           : 2**n-bit request vector transfer
//   out_valid/out_ready/out/out_last: n-bit index transfer, last-of-vector flag
//   busy                            : encoder is draining a vector
// Modports:
//   slave  - the encoder itself
//   master - the environment (vector source + index consumer)
// -----------------------------------------------------------------------------
interface seq_encoder_if
  import seq_encoder_pkg::*;
#(
  parameter int n = DEFAULT_N
) ();

  logic              in_valid;
  logic              in_ready;
  logic [(1<<n)-1:0] in;
  logic              out_valid;
  logic              out_ready;
  logic [n-1:0]      out;
  logic              out_last;
  logic              busy;

  modport slave (
    input  in_valid,
    output in_ready,
    input  in,
    output out_valid,
    input  out_ready,
    output out,
    output out_last,
    output busy
  );

  modport master (
    output in_valid,
    input  in_ready,
    output in,
    input  out_valid,
    output out_ready,
    input  out,
    input  out_last,
    input  busy
  );

endinterface

// File: rtl/seq_encoder_prio_enc.sv
// -----------------------------------------------------------------------------
// prio_enc
// Combinational priority encoder over a 2**n-bit vector.
//   vec  : input vector
//   idx  : index of the selected set bit (0 when vec is zero)
//   mask : one-hot mask of the selected bit
//   any  : at least one bit of vec is set
// Build option SEQ_ENCODER_LSB_FIRST_EN: when defined the lowest set bit wins,
// otherwise the highest set bit wins.
// -----------------------------------------------------------------------------
module prio_enc
  import seq_encoder_pkg::*;
#(
  parameter int n = DEFAULT_N
) (
  input  logic [(1<<n)-1:0] vec,
  output logic [n-1:0]      idx,
  output logic [(1<<n)-1:0] mask,
  output logic              any
);

  localparam int W = 1 << n;

  // Scan the vector so that the winning bit is the last one found.
  always_comb begin
    int sel;
    sel = 0;
`ifdef SEQ_ENCODER_LSB_FIRST_EN
    for (int i = W - 1; i >= 0; i--) begin
      if (vec[i]) begin
        sel = i;
      end else begin
        sel = sel;
      end
    end
`else
    for (int i = 0; i < W; i++) begin
      if (vec[i]) begin
        sel = i;
      end else begin
        sel = sel;
      end
    end
`endif
    idx  = sel[n-1:0];
    mask = {{(W-1){1'b0}}, 1'b1} << sel;
    any  = |vec;
  end

endmodule

// File: rtl/seq_encoder.sv
// -----------------------------------------------------------------------------
// seq_encoder
// Sequential encoder: accepts a 2**n-bit request vector and emits the index of
// every set bit, one per output handshake.  Default order is highest index
// first; defining SEQ_ENCODER_LSB_FIRST_EN reverses it to lowest first.
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset
//   en    - enable; low freezes state and blocks transfers on both sides
//   bus   - seq_encoder_if.slave (vector in, index out, busy)
// Outputs come only from the registered state/pending vector (plus en gating);
// there is no combinational path from bus.in to the index outputs.
// -----------------------------------------------------------------------------
module seq_encoder
  import seq_encoder_pkg::*;
#(
  parameter int n = DEFAULT_N
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  seq_encoder_if.slave       bus
);

  localparam int W = 1 << n;

  localparam logic [0:0] ST_IDLE  = IDLE;
  localparam logic [0:0] ST_DRAIN = DRAIN;

  logic [0:0]   state_r;
  logic [W-1:0] pending_r;

  logic [n-1:0] idx_s;
  logic [W-1:0] mask_s;
  logic         any_s;
  logic         in_ready_s;
  logic         out_valid_s;
  logic         out_last_s;
  logic         in_fire_s;
  logic         out_fire_s;

  prio_enc #(
    .n (n)
  ) u_prio_enc (
    .vec  (pending_r),
    .idx  (idx_s),
    .mask (mask_s),
    .any  (any_s)
  );

  // rst_n gates in_ready so the source sees no readiness while reset is held.
  assign in_ready_s  = rst_n & en & (state_r == ST_IDLE);
  assign out_valid_s = en & (state_r == ST_DRAIN) & any_s;
  assign out_last_s  = pop_is_one(VEC_MAX_W'(pending_r));
  assign in_fire_s   = bus.in_valid & in_ready_s;
  assign out_fire_s  = out_valid_s & bus.out_ready;

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = out_valid_s;
  assign bus.out       = idx_s;
  assign bus.out_last  = out_last_s;
  assign bus.busy      = (state_r == ST_DRAIN);

  // Drain FSM and pending-vector register; en low holds everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      pending_r <= {W{1'b0}};
    end else if (en) begin
      case (state_r)
        ST_IDLE: begin
          // A zero vector is consumed without entering DRAIN.
          if (in_fire_s && (bus.in != {W{1'b0}})) begin
            pending_r <= bus.in;
            state_r   <= ST_DRAIN;
          end else begin
            pending_r <= pending_r;
            state_r   <= ST_IDLE;
          end
        end
        ST_DRAIN: begin
          if (!any_s) begin
            // Nothing left to emit (cannot happen in normal operation).
            state_r <= ST_IDLE;
          end else if (out_fire_s) begin
            pending_r <= pending_r & ~mask_s;
            state_r   <= out_last_s ? ST_IDLE : ST_DRAIN;
          end else begin
            pending_r <= pending_r;
            state_r   <= ST_DRAIN;
          end
        end
        default: begin
          state_r   <= ST_IDLE;
          pending_r <= {W{1'b0}};
        end
      endcase
    end else begin
      state_r   <= state_r;
      pending_r <= pending_r;
    end
  end

endmodule
